// File: rtl/mult_sched_pkg.sv
// Shared types for the round-robin multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mult_comb.sv
// Unsigned combinational multiplier, full 2n-bit product.
module mult_comb #(
  parameter int n = 16
) (
  input  logic [n-1:0]   cand,
  input  logic [n-1:0]   plier,
  output logic [2*n-1:0] prod
);

  assign prod = (2*n)'(cand) * (2*n)'(plier);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  int unsigned       sum;
  logic [ID_W-1:0]   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // ptr is always below N_REQ, so one subtraction is enough to wrap
      sum = int'(ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = ID_W'(sum);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mult_rr_sched.sv
// Shares one combinational multiplier among N_REQ requesters, round-robin,
// returning a registered, id-tagged product on a valid/ready channel.
module mult_rr_sched
  import mult_sched_pkg::*;
#(
  parameter  int n     = 16,
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*n-1:0] req_cand,
  input  logic [N_REQ*n-1:0] req_plier,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*n-1:0]     rsp_prod,
  output logic [ID_W-1:0]    rsp_id
);

  sched_state_t      state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  logic [n-1:0]      cand_q;
  logic [n-1:0]      plier_q;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any;
  logic [2*n-1:0]    prod;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  mult_comb #(.n(n)) u_mult (
    .cand  (cand_q),
    .plier (plier_q),
    .prod  (prod)
  );

  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      cand_q    <= '0;
      plier_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            cand_q  <= req_cand[gnt_idx*n +: n];
            plier_q <= req_plier[gnt_idx*n +: n];
            id_q    <= gnt_idx;
            ptr     <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          rsp_prod  <= prod;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed bench for mult_rr_sched with n=4, N_REQ=3.
module tb_mult_rr_sched;

  localparam int n     = 4;
  localparam int N_REQ = 3;
  localparam int ID_W  = $clog2(N_REQ);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*n-1:0] req_cand;
  logic [N_REQ*n-1:0] req_plier;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*n-1:0]     rsp_prod;
  logic [ID_W-1:0]    rsp_id;

  int checks   = 0;
  int failures = 0;

  mult_rr_sched #(.n(n), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cand  (req_cand),
    .req_plier (req_plier),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [n-1:0] c, input logic [n-1:0] p);
    req_cand[i*n +: n]  = c;
    req_plier[i*n +: n] = p;
  endtask

  // expected round-robin sequence from reset with all three requesters valid
  int          rr_id[4]   = '{0, 1, 2, 0};
  int          rr_prod[4] = '{63, 32, 225, 63};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_cand  = '0;
    req_plier = '0;
    rsp_ready = 1'b0;

    // reset, with requests present to show req_ready is held low
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_prod",  32'(rsp_prod),  0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick(); tick(); tick();
    chk("idle_req_ready", 32'(req_ready), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);

    // single request from requester 1
    rsp_ready = 1'b1;
    set_op(1, 4'd6, 4'd5);
    req_valid = 3'b010;
    #1;
    chk("single_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    chk("single_calc_valid", 32'(rsp_valid), 0);
    chk("single_calc_ready", 32'(req_ready), 0);
    tick();
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_prod",  32'(rsp_prod),  30);
    chk("single_id",    32'(rsp_id),    1);
    tick();
    chk("single_done", 32'(rsp_valid), 0);

    // round-robin from reset, all valid continuously
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    set_op(0, 4'd9, 4'd7);
    set_op(1, 4'd4, 4'd8);
    set_op(2, 4'd15, 4'd15);
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << rr_id[k]));
      tick();
      chk($sformatf("rr%0d_calc_ready", k), 32'(req_ready), 0);
      tick();
      chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("rr%0d_id", k),    32'(rsp_id),    32'(rr_id[k]));
      chk($sformatf("rr%0d_prod", k),  32'(rsp_prod),  32'(rr_prod[k]));
      chk($sformatf("rr%0d_resp_ready", k), 32'(req_ready), 0);
      tick();
    end
    req_valid = '0;

    // back-pressure: ptr is now 1
    rsp_ready = 1'b0;
    set_op(1, 4'd8, 4'd3);
    req_valid = 3'b010;
    #1;
    chk("bp_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = 3'b111;
    tick();
    chk("bp_valid", 32'(rsp_valid), 1);
    chk("bp_prod",  32'(rsp_prod),  24);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("bp_hold%0d_prod", k),  32'(rsp_prod),  24);
      chk($sformatf("bp_hold%0d_id", k),    32'(rsp_id),    1);
      chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready), 0);
    end
    req_valid = 3'b001;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 0);
    chk("bp_idle_ready",    32'(req_ready), 32'b001);
    req_valid = '0;
    #1;
    chk("drop_ready", 32'(req_ready), 0);
    tick();

    // reset in CALC discards the operation; ptr is 2, only req 0 valid
    set_op(0, 4'd15, 4'd15);
    req_valid = 3'b001;
    #1;
    chk("mid_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_quiet%0d", k), 32'(rsp_valid), 0);
    end
    req_valid = 3'b011;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'b001);
    set_op(2, 4'd5, 4'd11);
    req_valid = 3'b100;
    #1;
    chk("mid_req2_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    tick();
    chk("mid_req2_valid", 32'(rsp_valid), 1);
    chk("mid_req2_id",    32'(rsp_id),    2);
    chk("mid_req2_prod",  32'(rsp_prod),  55);
    tick();

    // boundary operands
    set_op(0, 4'd0, 4'd15);
    req_valid = 3'b001;
    #1;
    chk("zero_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    tick();
    chk("zero_valid", 32'(rsp_valid), 1);
    chk("zero_prod",  32'(rsp_prod),  0);
    tick();
    set_op(1, 4'd15, 4'd15);
    req_valid = 3'b010;
    #1;
    chk("max_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    tick();
    chk("max_prod", 32'(rsp_prod), 32'hE1);
    chk("max_id",   32'(rsp_id),   1);
    tick();
    chk("max_done", 32'(rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
